// File: rtl/esm_issue_buffer.sv
// ---------------------------------------------------------------------------
// esm_issue_buffer
//
// Instruction window in front of ESM_Core_IDA. It takes decoded instructions,
// puts each one in the lowest free slot, and reports that slot number to
// ESM_Core_IDA as buffer_index. The core sends back a dependency-free mask.
// The buffer issues one eligible instruction per cycle downstream over a
// valid/ready handshake, using rotating priority.
//
// Optional feature (compile-time macro ESM_ISSUE_STALL_CNT_EN):
//   Adds output stall_cycles[15:0]. It counts the cycles in which the window
//   is non-empty but nothing is eligible, saturates at 16'hFFFF, and is
//   cleared by rst or flush.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   flush             synchronous clear of the whole window (beats alloc/issue)
//   in_valid/in_ready upstream handshake, Instr_in = incoming word
//   alloc_fire        accepted allocation (ESM_Core_IDA table write strobe)
//   buffer_index      slot being allocated this cycle (lowest free slot)
//   valid_entries     occupied-slot mask, bit i = slot i
//   independent_instr dependency-free mask from ESM_Core_IDA, bit i = slot i
//   issue_valid/issue_ready downstream handshake
//   issue_instr, issue_index selected word and its slot (0 when idle)
//   occupancy         number of occupied slots
//   stall_cycles      (only with ESM_ISSUE_STALL_CNT_EN) stall counter
// ---------------------------------------------------------------------------
module esm_issue_buffer #(
  parameter int Instruction_word_size = 32,
  parameter int bs                    = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [Instruction_word_size-1:0] Instr_in,
  output logic                             alloc_fire,
  output logic [$clog2(bs)-1:0]            buffer_index,
  output logic [0:bs-1]                    valid_entries,
  input  logic [0:bs-1]                    independent_instr,
  output logic                             issue_valid,
  input  logic                             issue_ready,
  output logic [Instruction_word_size-1:0] issue_instr,
  output logic [$clog2(bs)-1:0]            issue_index,
  output logic [$clog2(bs):0]              occupancy
`ifdef ESM_ISSUE_STALL_CNT_EN
  ,
  output logic [15:0]                      stall_cycles
`endif
);

  localparam int IW = $clog2(bs);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] BS_CNT = CW'(bs);

  logic [Instruction_word_size-1:0] mem [bs];
  logic [IW-1:0] rr_ptr;

  logic [IW-1:0] free_idx;
  logic          free_found;
  logic [0:bs-1] eligible;
  logic [IW-1:0] sel_idx;
  logic          sel_found;
  logic [IW-1:0] cand;
  logic          issue_fire;

  // Lowest free slot. When the window is full this stays 0, but in_ready is
  // low then, so the value is never used.
  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = 0; i < bs; i++) begin
      if (!free_found && !valid_entries[i]) begin
        free_idx   = IW'(i);
        free_found = 1'b1;
      end
    end
  end

  // Rotating-priority pick: scan rr_ptr, rr_ptr+1, ... The index wraps for
  // free because bs is a power of two and cand is IW bits wide.
  always_comb begin
    eligible  = valid_entries & independent_instr;
    sel_idx   = '0;
    sel_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < bs; k++) begin
      cand = rr_ptr + IW'(k);
      if (!sel_found && eligible[cand]) begin
        sel_idx   = cand;
        sel_found = 1'b1;
      end
    end
  end

  // in_ready depends only on flush and the registered occupancy. There is
  // deliberately no path from issue_ready, so a full window stays closed even
  // in a cycle where an issue fires.
  assign in_ready     = ~flush & (occupancy < BS_CNT);
  assign alloc_fire   = in_valid & in_ready;
  assign buffer_index = free_idx;

  assign issue_valid = sel_found;
  assign issue_index = sel_found ? sel_idx : '0;
  assign issue_instr = sel_found ? mem[sel_idx] : '0;
  // A fire presented during a flush cycle is dropped.
  assign issue_fire  = sel_found & issue_ready & ~flush;

  // ---- state update: control (reset) --------------------------------------
  // The issued slot is occupied and the allocated slot is free, so the two
  // can never be the same slot within one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_entries <= '0;
      occupancy     <= '0;
      rr_ptr        <= '0;
    end else if (flush) begin
      valid_entries <= '0;
      occupancy     <= '0;
      rr_ptr        <= '0;
    end else begin
      if (alloc_fire) valid_entries[free_idx] <= 1'b1;
      if (issue_fire) begin
        valid_entries[sel_idx] <= 1'b0;
        rr_ptr                 <= sel_idx + IW'(1);
      end
      occupancy <= occupancy + CW'(alloc_fire) - CW'(issue_fire);
    end
  end

  // ---- state update: data (no reset) --------------------------------------
  always_ff @(posedge clk) begin
    if (alloc_fire) mem[free_idx] <= Instr_in;
  end

`ifdef ESM_ISSUE_STALL_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (flush) begin
      stall_cycles <= '0;
    end else if ((occupancy != '0) && !sel_found) begin
      stall_cycles <= sat_inc16(stall_cycles);
    end
  end
`endif

endmodule
